// File: rtl/gamma_loader_if.sv
// Control, stream and table-write signals between the command decoder,
// the gamma loader and the gamma correction stage.
interface gamma_loader_if;
  logic       load_start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       en_wr;
  logic       en_value;
  logic       gamma_wr;
  logic [9:0] gamma_wr_addr;
  logic [7:0] gamma_value;
  logic       gamma_en;
  logic       busy;
  logic       done;

  modport master (
    output load_start, s_valid, s_data, en_wr, en_value,
    input  s_ready, gamma_wr, gamma_wr_addr, gamma_value, gamma_en, busy, done
  );

  modport slave (
    input  load_start, s_valid, s_data, en_wr, en_value,
    output s_ready, gamma_wr, gamma_wr_addr, gamma_value, gamma_en, busy, done
  );
endinterface

// File: rtl/gamma_loader.sv
// Write-side sequencer for the 768-entry gamma table: identity fill after reset,
// then host curve loads from a byte stream into consecutive addresses.
module gamma_loader (
  input logic           clk_sys,
  input logic           reset,
  gamma_loader_if.slave bus
);

  localparam logic [9:0] LastAddr = 10'd767;

  typedef enum logic [1:0] {StInit, StIdle, StLoad} state_e;

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       en_q, en_d;
  logic       wr_q, wr_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] value_q, value_d;
  logic       gen_q, gen_d;
  logic       done_q, done_d;
  logic       init_last;
  logic       xfer;
  logic       s_ready;
  logic       busy;

  // The fill leaves INIT only once the final identity write is on the bus.
  assign init_last = wr_q && (addr_q == LastAddr);
  // A restart in the same cycle wins over a handshake; that byte is dropped.
  assign xfer      = (state_q == StLoad) && bus.s_valid && !bus.load_start;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StInit;
      cnt_q     <= 10'd0;
      pending_q <= 1'b0;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 10'd0;
      value_q   <= 8'd0;
      gen_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      gen_q     <= gen_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: begin
        if (init_last) state_d = (pending_q || bus.load_start) ? StLoad : StIdle;
      end
      StIdle: begin
        if (bus.load_start) state_d = StLoad;
      end
      StLoad: begin
        if (xfer && (cnt_q == LastAddr)) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    value_d   = value_q;
    done_d    = 1'b0;
    en_d      = bus.en_wr ? bus.en_value : en_q;
    // Bypass correction whenever the table may be partially written.
    gen_d     = en_q && (state_q == StIdle);
    unique case (state_q)
      StInit: begin
        if (bus.load_start) pending_d = 1'b1;
        if (init_last) begin
          pending_d = 1'b0;
          cnt_d     = 10'd0;
        end else begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          value_d = cnt_q[7:0];
          if (cnt_q != LastAddr) cnt_d = cnt_q + 10'd1;
        end
      end
      StIdle: begin
        if (bus.load_start) cnt_d = 10'd0;
      end
      StLoad: begin
        if (bus.load_start) begin
          cnt_d = 10'd0;
        end else if (xfer) begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          value_d = bus.s_data;
          done_d  = (cnt_q == LastAddr);
          cnt_d   = (cnt_q == LastAddr) ? 10'd0 : cnt_q + 10'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    s_ready = (state_q == StLoad);
    busy    = (state_q != StIdle);
  end

  assign bus.s_ready       = s_ready;
  assign bus.busy          = busy;
  assign bus.gamma_wr      = wr_q;
  assign bus.gamma_wr_addr = addr_q;
  assign bus.gamma_value   = value_q;
  assign bus.gamma_en      = gen_q;
  assign bus.done          = done_q;

endmodule
